vuprs_adc_sample_scheduler: RTL
===============================

Name: vuprs_adc_sample_scheduler

Overview:
Sequences the two AD7606 controller instances (ADC-A, ADC-B) from a single programmable sample clock. It issues a shared trigger pulse, waits until both controllers report completion, and flags a sample as valid. It also handles burst length, start/stop, per-sample timeout, overrun counting and error latching. It replaces the free-running toggle trigger in the ADC top level and feeds downstream capture logic.

Parameters:
TRIG_HIGH_CYCLES, 4, clk cycles the trigger is held high per sample
TIMEOUT_CYCLES, 5000, max clk cycles from trigger rise to both-complete before timeout
DIV_WIDTH, 24, width of the period register
CNT_WIDTH, 32, width of the sample index and overrun counters

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous active-high reset
cfg_period  in  DIV_WIDTH  clk cycles between trigger rising edges; latched at start
cfg_burst_len  in  16  samples per run; 0 = continuous until stop; latched at start
start  in  1  one-cycle pulse; begins a run
stop  in  1  one-cycle pulse; ends the run after any in-flight sample
adc_reset_down_a  in  1  ADC-A controller reset sequence finished
adc_reset_down_b  in  1  ADC-B controller reset sequence finished
adc_sampling_a  in  1  ADC-A controller busy (1 = converting/reading)
adc_sampling_b  in  1  ADC-B controller busy
adc_error_a  in  1  ADC-A controller error flag
adc_error_b  in  1  ADC-B controller error flag
adc_trigger  out  1  trigger to both controllers (rising-edge sensitive)
sample_valid  out  1  one-cycle pulse when both ADCs have completed a sample
sample_index  out  CNT_WIDTH  index of the current or last valid sample; cleared at start
overrun_cnt  out  CNT_WIDTH  period ticks missed because a sample was still in flight
run_busy  out  1  high from start acceptance until the run ends
run_done  out  1  one-cycle pulse when the run ends
err_flag  out  1  sticky; an adc_error seen during a run
timeout_flag  out  1  sticky; a sample exceeded TIMEOUT_CYCLES

Behaviour:
- Clocking: single clock domain. All inputs are synchronous to clk. All outputs are registered.
- Reset: synchronous, active-high. During rst, all outputs are 0, the FSM is in IDLE and all counters are 0.
- Period clamp: effective period P = max(cfg_period, TRIG_HIGH_CYCLES+2).
- FSM states: IDLE, WAIT_RDY, TRIG, WAIT_BUSY, WAIT_DONE, HOLD.
- IDLE: start moves the FSM to WAIT_RDY; run_busy=1; the period and burst length are latched; sample_index, err_flag and timeout_flag are cleared. overrun_cnt is cleared only by rst. start is ignored when not in IDLE.
- WAIT_RDY: waits until adc_reset_down_a && adc_reset_down_b, then goes to TRIG on the next cycle. The period timer is zeroed on entry to TRIG.
- TRIG: adc_trigger=1 for exactly TRIG_HIGH_CYCLES cycles, then 0, then WAIT_BUSY.
- WAIT_BUSY: waits until both adc_sampling are 1 (either order, not necessarily in the same cycle), then WAIT_DONE.
- WAIT_DONE: waits until both adc_sampling are 0. On that cycle, sample_valid pulses, sample_index is incremented (first valid sample index = 1), and the FSM goes to HOLD.
- Timeout: a counter starts at the trigger rise and runs through WAIT_BUSY and WAIT_DONE. Reaching TIMEOUT_CYCLES sets timeout_flag, suppresses sample_valid and goes to HOLD; sample_index is not incremented.
- Period timer: counts 0..P-1 continuously while run_busy. A tick occurs at wrap. A tick in HOLD goes to TRIG, unless the burst has completed or a stop is pending, in which case the run ends.
- Overrun: a tick while in TRIG, WAIT_BUSY or WAIT_DONE increments overrun_cnt (saturating) and is otherwise dropped. The next trigger then waits for the following tick.
- Burst completion: when sample_index reaches the latched burst length (burst length non-zero), the run ends on leaving WAIT_DONE. Timed-out samples do not count toward the burst.
- Stop: stop in any run state sets stop_pending. A sample already in flight completes normally. In WAIT_RDY or HOLD, the run ends next cycle. adc_trigger never truncates below TRIG_HIGH_CYCLES.
- Run end: go to IDLE, run_busy=0, run_done pulses once, adc_trigger=0.
- Errors: adc_error_a or adc_error_b high in any run state sets err_flag (sticky until next start). Sequencing is unaffected.
- Simultaneous events: start and stop in the same cycle in IDLE: start is accepted and the stop is discarded. A tick in the same cycle as sample completion is treated as occurring in HOLD, so it retriggers and is not counted as an overrun.
- rst asserted mid-run: adc_trigger drops to 0 the same clock edge. No run_done pulse.

Test Plan:
- cfg_period=500, burst=3, start; ADC models busy for 200 cycles -> triggers spaced 500 clk, each high 4 cycles; 3 sample_valid pulses, sample_index 1,2,3; run_done once; overrun_cnt=0.
- cfg_period=100, burst=4; busy for 250 cycles -> overrun_cnt=2 after the first sample; trigger spacing 300; 4 valid samples.
- continuous (burst=0), stop asserted mid-WAIT_DONE -> that sample still yields sample_valid; no further trigger; run_done within 1 cycle of completion.
- ADC-B never asserts sampling; TIMEOUT_CYCLES=5000 -> timeout_flag=1 at cycle 5000 after trigger rise; no sample_valid; next tick retriggers.
- adc_reset_down_b held low 1000 cycles after start -> no trigger until it rises; first trigger on the following cycle.
- cfg_period=2 -> effective period 6; adc_error_a single-cycle pulse -> err_flag stays 1 until next start; rst mid-TRIG -> adc_trigger=0 after that edge; all outputs 0.

Source files
------------

// File: rtl/vuprs_adc_sample_scheduler.sv
// vuprs_adc_sample_scheduler
// Drives a shared trigger to the two AD7606 controllers from a programmable
// sample period, waits for both to finish, and reports valid samples.
// Also handles burst length, start/stop, a per-sample timeout, overrun
// counting and sticky error/timeout flags.
module vuprs_adc_sample_scheduler #(
    parameter int TRIG_HIGH_CYCLES = 4,
    parameter int TIMEOUT_CYCLES   = 5000,
    parameter int DIV_WIDTH        = 24,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] cfg_period,
    input  logic [15:0]          cfg_burst_len,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 adc_reset_down_a,
    input  logic                 adc_reset_down_b,
    input  logic                 adc_sampling_a,
    input  logic                 adc_sampling_b,
    input  logic                 adc_error_a,
    input  logic                 adc_error_b,
    output logic                 adc_trigger,
    output logic                 sample_valid,
    output logic [CNT_WIDTH-1:0] sample_index,
    output logic [CNT_WIDTH-1:0] overrun_cnt,
    output logic                 run_busy,
    output logic                 run_done,
    output logic                 err_flag,
    output logic                 timeout_flag
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        TRIG,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD
    } state_t;

    localparam int TRIG_W = $clog2(TRIG_HIGH_CYCLES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DIV_WIDTH-1:0] P_MIN = DIV_WIDTH'(TRIG_HIGH_CYCLES + 2);

    // The period must leave room for the full trigger pulse plus a low cycle.
    function automatic logic [DIV_WIDTH-1:0] clamp_period(input logic [DIV_WIDTH-1:0] p);
        return (p < P_MIN) ? P_MIN : p;
    endfunction

    // Overrun counter holds at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    state_t               state;
    logic [DIV_WIDTH-1:0] period_q;
    logic [15:0]          burst_q;
    logic [DIV_WIDTH-1:0] ptimer;
    logic [TRIG_W-1:0]    trig_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 seen_a;
    logic                 seen_b;
    logic                 stop_pending;

    logic                 tick;
    logic                 both_rdy;
    logic                 both_busy;
    logic                 both_idle;
    logic                 tmo_hit;
    logic                 trig_last;
    logic                 stop_req;
    logic [CNT_WIDTH-1:0] index_next;
    logic                 burst_hit;

    assign tick       = run_busy && (ptimer == period_q - DIV_WIDTH'(1));
    assign both_rdy   = adc_reset_down_a && adc_reset_down_b;
    assign both_busy  = (adc_sampling_a || seen_a) && (adc_sampling_b || seen_b);
    assign both_idle  = !adc_sampling_a && !adc_sampling_b;
    assign tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign trig_last  = (trig_cnt == TRIG_W'(TRIG_HIGH_CYCLES - 1));
    assign stop_req   = stop || stop_pending;
    assign index_next = sample_index + CNT_WIDTH'(1);
    assign burst_hit  = (burst_q != 16'd0) && (index_next == CNT_WIDTH'(burst_q));

    // Free-running period timer; restarts when the first trigger of a run fires.
    always_ff @(posedge clk) begin
        if (rst || !run_busy) begin
            ptimer <= '0;
        end else if (tick || (state == WAIT_RDY && both_rdy && !stop_req)) begin
            ptimer <= '0;
        end else begin
            ptimer <= ptimer + DIV_WIDTH'(1);
        end
    end

    // Run sequencing FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            adc_trigger  <= 1'b0;
            sample_valid <= 1'b0;
            sample_index <= '0;
            overrun_cnt  <= '0;
            run_busy     <= 1'b0;
            run_done     <= 1'b0;
            err_flag     <= 1'b0;
            timeout_flag <= 1'b0;
            trig_cnt     <= '0;
            tmo_cnt      <= '0;
            seen_a       <= 1'b0;
            seen_b       <= 1'b0;
            stop_pending <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            run_done     <= 1'b0;

            if (state != IDLE && (adc_error_a || adc_error_b)) begin
                err_flag <= 1'b1;
            end
            // A stop seen mid-sample is remembered; the sample still completes.
            if (state != IDLE && stop) begin
                stop_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= WAIT_RDY;
                        run_busy     <= 1'b1;
                        period_q     <= clamp_period(cfg_period);
                        burst_q      <= cfg_burst_len;
                        sample_index <= '0;
                        err_flag     <= 1'b0;
                        timeout_flag <= 1'b0;
                        stop_pending <= 1'b0;
                    end
                end

                WAIT_RDY: begin
                    if (stop_req) begin
                        state        <= IDLE;
                        run_busy     <= 1'b0;
                        run_done     <= 1'b1;
                        adc_trigger  <= 1'b0;
                        stop_pending <= 1'b0;
                    end else if (both_rdy) begin
                        state       <= TRIG;
                        adc_trigger <= 1'b1;
                        trig_cnt    <= '0;
                        tmo_cnt     <= '0;
                        seen_a      <= 1'b0;
                        seen_b      <= 1'b0;
                    end
                end

                TRIG: begin
                    // Busy may already rise while the trigger is still high.
                    seen_a  <= seen_a || adc_sampling_a;
                    seen_b  <= seen_b || adc_sampling_b;
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (tick) begin
                        overrun_cnt <= sat_inc(overrun_cnt);
                    end
                    if (trig_last) begin
                        adc_trigger <= 1'b0;
                        state       <= WAIT_BUSY;
                    end else begin
                        trig_cnt <= trig_cnt + TRIG_W'(1);
                    end
                end

                WAIT_BUSY: begin
                    seen_a  <= seen_a || adc_sampling_a;
                    seen_b  <= seen_b || adc_sampling_b;
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (tick) begin
                        overrun_cnt <= sat_inc(overrun_cnt);
                    end
                    if (tmo_hit) begin
                        timeout_flag <= 1'b1;
                        state        <= HOLD;
                    end else if (both_busy) begin
                        state <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (tmo_hit) begin
                        timeout_flag <= 1'b1;
                        state        <= HOLD;
                        if (tick) begin
                            overrun_cnt <= sat_inc(overrun_cnt);
                        end
                    end else if (both_idle) begin
                        sample_valid <= 1'b1;
                        sample_index <= index_next;
                        if (burst_hit || stop_req) begin
                            state        <= IDLE;
                            run_busy     <= 1'b0;
                            run_done     <= 1'b1;
                            adc_trigger  <= 1'b0;
                            stop_pending <= 1'b0;
                        end else if (tick) begin
                            // Tick coinciding with completion counts as a HOLD tick.
                            state       <= TRIG;
                            adc_trigger <= 1'b1;
                            trig_cnt    <= '0;
                            tmo_cnt     <= '0;
                            seen_a      <= 1'b0;
                            seen_b      <= 1'b0;
                        end else begin
                            state <= HOLD;
                        end
                    end else if (tick) begin
                        overrun_cnt <= sat_inc(overrun_cnt);
                    end
                end

                HOLD: begin
                    if (stop_req) begin
                        state        <= IDLE;
                        run_busy     <= 1'b0;
                        run_done     <= 1'b1;
                        adc_trigger  <= 1'b0;
                        stop_pending <= 1'b0;
                    end else if (tick) begin
                        state       <= TRIG;
                        adc_trigger <= 1'b1;
                        trig_cnt    <= '0;
                        tmo_cnt     <= '0;
                        seen_a      <= 1'b0;
                        seen_b      <= 1'b0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    run_busy    <= 1'b0;
                    adc_trigger <= 1'b0;
                end
            endcase
        end
    end

endmodule
